// File: rtl/idex_operand_stage.sv
// ---------------------------------------------------------------------------
// idex_operand_stage
//
// ID/EX pipeline register for the 16-bit pipelined core, together with the
// EX-stage operand forwarding network that produces the final A/B operands
// consumed by the ALU and reduction unit.
//
// Ports:
//   clk, rst_n            core clock (rising edge), asynchronous active-low reset
//   stall                 hold the ID/EX contents this cycle
//   flush                 replace the ID/EX contents with a bubble (beats stall)
//   id_*                  decoded instruction fields and register-file data from ID
//   exmem_reg_write/rd/result   writeback info of the instruction in EX/MEM
//   memwb_reg_write/rd/result   writeback info of the instruction in MEM/WB
//   ex_valid, ex_opcode, ex_rd, ex_reg_write   registered control to EX
//   ex_op_a, ex_op_b      forwarded operands (B may be the immediate)
//   ex_fwd_a, ex_fwd_b    forwarding source: 00 register, 01 MEM/WB, 10 EX/MEM
// ---------------------------------------------------------------------------
module idex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_reg_write,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_opcode,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b
);

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    logic              r_valid;
    logic [OP_W-1:0]   r_opcode;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic              r_use_imm;
    logic              r_reg_write;

    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_rt;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_rt_val;

    // Forwarding select for each source. The younger producer (EX/MEM) wins
    // over MEM/WB; R0 never forwards, and a bubble in EX forwards nothing.
    always_comb begin
        w_fwd_a  = FWD_REG;
        w_fwd_rt = FWD_REG;
        if (r_valid && (r_rs != '0)) begin
            if (exmem_reg_write && (exmem_rd == r_rs)) begin
                w_fwd_a = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd == r_rs)) begin
                w_fwd_a = FWD_MEMWB;
            end
        end
        if (r_valid && (r_rt != '0)) begin
            if (exmem_reg_write && (exmem_rd == r_rt)) begin
                w_fwd_rt = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd == r_rt)) begin
                w_fwd_rt = FWD_MEMWB;
            end
        end
    end

    // Operand values. R0 reads as zero even if stale data was captured for it.
    always_comb begin
        w_op_a   = r_rs_data;
        w_rt_val = r_rt_data;
        if (r_rs == '0) begin
            w_op_a = '0;
        end else if (w_fwd_a == FWD_EXMEM) begin
            w_op_a = exmem_result;
        end else if (w_fwd_a == FWD_MEMWB) begin
            w_op_a = memwb_result;
        end
        if (r_rt == '0) begin
            w_rt_val = '0;
        end else if (w_fwd_rt == FWD_EXMEM) begin
            w_rt_val = exmem_result;
        end else if (w_fwd_rt == FWD_MEMWB) begin
            w_rt_val = memwb_result;
        end
    end

    // Pipeline register: flush beats stall beats load. During a stall the
    // stored operand data is refreshed with the forwarded values so that a
    // producer retiring out of MEM/WB mid-stall does not lose its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_opcode    <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_opcode    <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (stall) begin
            r_rs_data   <= w_op_a;
            r_rt_data   <= w_rt_val;
        end else begin
            r_valid     <= id_valid;
            r_opcode    <= id_opcode;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rd        <= id_rd;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_use_imm   <= id_use_imm;
            r_reg_write <= id_reg_write & id_valid;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_opcode    = r_opcode;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_reg_write & r_valid;
    assign ex_op_a      = w_op_a;
    assign ex_fwd_a     = w_fwd_a;
    // With an immediate operand the rt path is not used, so B reports no forward.
    assign ex_op_b      = r_use_imm ? r_imm : w_rt_val;
    assign ex_fwd_b     = r_use_imm ? FWD_REG : w_fwd_rt;

endmodule

// File: tb/tb_idex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_idex_operand_stage
//
// Self-checking bench for idex_operand_stage. A driver applies one stimulus
// vector per clock, predicts the DUT outputs from a behavioural model of the
// stage and queues the prediction; a monitor pops and compares at each
// falling edge. Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_idex_operand_stage;

    typedef struct {
        logic        rstN;
        logic        stall;
        logic        flush;
        logic        idValid;
        logic [3:0]  opcode;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic [15:0] rsData;
        logic [15:0] rtData;
        logic [15:0] imm;
        logic        useImm;
        logic        regWrite;
        logic        exWe;
        logic [3:0]  exRd;
        logic [15:0] exRes;
        logic        wbWe;
        logic [3:0]  wbRd;
        logic [15:0] wbRes;
    } stim_t;

    // Contents of the ID/EX latch as the architecture describes it.
    typedef struct {
        logic        valid;
        logic [3:0]  opcode;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic [15:0] rsData;
        logic [15:0] rtData;
        logic [15:0] imm;
        logic        useImm;
        logic        regWrite;
    } model_t;

    typedef struct {
        logic        valid;
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic        regWrite;
        logic [15:0] opA;
        logic [15:0] opB;
        logic [15:0] rtVal;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
    } exp_t;

    typedef struct {
        logic [15:0] val;
        logic [1:0]  src;
    } operand_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic [3:0]  id_rd;
    logic [15:0] id_rs_data;
    logic [15:0] id_rt_data;
    logic [15:0] id_imm;
    logic        id_use_imm;
    logic        id_reg_write;
    logic        exmem_reg_write;
    logic [3:0]  exmem_rd;
    logic [15:0] exmem_result;
    logic        memwb_reg_write;
    logic [3:0]  memwb_rd;
    logic [15:0] memwb_result;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic        ex_reg_write;
    logic [15:0] ex_op_a;
    logic [15:0] ex_op_b;
    logic [1:0]  ex_fwd_a;
    logic [1:0]  ex_fwd_b;

    int     checkCount = 0;
    int     errorCount = 0;
    exp_t   expQ[$];
    model_t model;

    idex_operand_stage #(.DATA_W(16), .REG_W(4), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A register read as seen by EX: R0 is zero, the youngest in-flight
    // writer of the register supplies the value, otherwise the file data.
    function automatic operand_t readOperand(model_t m, logic [3:0] spec,
                                             logic [15:0] stored, stim_t s);
        operand_t r;
        r.val = stored;
        r.src = 2'd0;
        if (spec == 4'd0) begin
            r.val = 16'h0000;
        end else if (m.valid && s.exWe && s.exRd == spec) begin
            r.val = s.exRes;
            r.src = 2'd2;
        end else if (m.valid && s.wbWe && s.wbRd == spec) begin
            r.val = s.wbRes;
            r.src = 2'd1;
        end
        return r;
    endfunction

    function automatic exp_t refOutputs(model_t m, stim_t s);
        exp_t     e;
        operand_t a;
        operand_t b;
        a = readOperand(m, m.rs, m.rsData, s);
        b = readOperand(m, m.rt, m.rtData, s);
        e.valid    = m.valid;
        e.opcode   = m.opcode;
        e.rd       = m.rd;
        e.regWrite = m.regWrite && m.valid;
        e.opA      = a.val;
        e.rtVal    = b.val;
        e.fwdA     = a.src;
        e.opB      = m.useImm ? m.imm : b.val;
        e.fwdB     = m.useImm ? 2'd0 : b.src;
        return e;
    endfunction

    function automatic model_t emptyModel();
        model_t m;
        m.valid = 1'b0; m.opcode = 4'd0; m.rs = 4'd0; m.rt = 4'd0; m.rd = 4'd0;
        m.rsData = 16'h0; m.rtData = 16'h0; m.imm = 16'h0;
        m.useImm = 1'b0; m.regWrite = 1'b0;
        return m;
    endfunction

    function automatic model_t refNext(model_t m, stim_t s, exp_t e);
        model_t n;
        n = m;
        if (!s.rstN || s.flush) begin
            n = emptyModel();
        end else if (s.stall) begin
            n.rsData = e.opA;
            n.rtData = e.rtVal;
        end else begin
            n.valid    = s.idValid;
            n.opcode   = s.opcode;
            n.rs       = s.rs;
            n.rt       = s.rt;
            n.rd       = s.rd;
            n.rsData   = s.rsData;
            n.rtData   = s.rtData;
            n.imm      = s.imm;
            n.useImm   = s.useImm;
            n.regWrite = s.regWrite && s.idValid;
        end
        return n;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s.rstN = 1'b1; s.stall = 1'b0; s.flush = 1'b0; s.idValid = 1'b0;
        s.opcode = 4'd0; s.rs = 4'd0; s.rt = 4'd0; s.rd = 4'd0;
        s.rsData = 16'h0; s.rtData = 16'h0; s.imm = 16'h0;
        s.useImm = 1'b0; s.regWrite = 1'b0;
        s.exWe = 1'b0; s.exRd = 4'd0; s.exRes = 16'h0;
        s.wbWe = 1'b0; s.wbRd = 4'd0; s.wbRes = 16'h0;
        return s;
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s = idleStim();
        s.rstN     = ($urandom_range(0, 59) != 0);
        s.stall    = ($urandom_range(0, 4) == 0);
        s.flush    = ($urandom_range(0, 9) == 0);
        s.idValid  = ($urandom_range(0, 4) != 0);
        s.opcode   = 4'($urandom);
        s.rs       = 4'($urandom_range(0, 7));
        s.rt       = 4'($urandom_range(0, 7));
        s.rd       = 4'($urandom_range(0, 7));
        s.rsData   = 16'($urandom);
        s.rtData   = 16'($urandom);
        s.imm      = 16'($urandom);
        s.useImm   = ($urandom_range(0, 3) == 0);
        s.regWrite = $urandom_range(0, 1) != 0;
        s.exWe     = $urandom_range(0, 1) != 0;
        s.exRd     = 4'($urandom_range(0, 7));
        s.exRes    = 16'($urandom);
        s.wbWe     = $urandom_range(0, 1) != 0;
        s.wbRd     = 4'($urandom_range(0, 7));
        s.wbRes    = 16'($urandom);
        return s;
    endfunction

    // Applies one vector just after a rising edge, queues the prediction
    // for this cycle, then advances the model across the next edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        rst_n = s.rstN; stall = s.stall; flush = s.flush;
        id_valid = s.idValid; id_opcode = s.opcode;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_rs_data = s.rsData; id_rt_data = s.rtData; id_imm = s.imm;
        id_use_imm = s.useImm; id_reg_write = s.regWrite;
        exmem_reg_write = s.exWe; exmem_rd = s.exRd; exmem_result = s.exRes;
        memwb_reg_write = s.wbWe; memwb_rd = s.wbRd; memwb_result = s.wbRes;
        if (!s.rstN) model = emptyModel();
        e = refOutputs(model, s);
        expQ.push_back(e);
        @(posedge clk);
        model = refNext(model, s, e);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Monitor: compares the DUT against the oldest pending prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("ex_valid",     16'(ex_valid),     16'(e.valid));
                checkOutput("ex_opcode",    16'(ex_opcode),    16'(e.opcode));
                checkOutput("ex_rd",        16'(ex_rd),        16'(e.rd));
                checkOutput("ex_reg_write", 16'(ex_reg_write), 16'(e.regWrite));
                checkOutput("ex_op_a",      ex_op_a,           e.opA);
                checkOutput("ex_op_b",      ex_op_b,           e.opB);
                checkOutput("ex_fwd_a",     16'(ex_fwd_a),     16'(e.fwdA));
                checkOutput("ex_fwd_b",     16'(ex_fwd_b),     16'(e.fwdB));
            end
        end
    end

    initial begin
        stim_t s;
        stim_t rsv;
        int    waitCycles;
        model = emptyModel();
        s = idleStim();
        s.rstN = 1'b0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_use_imm = 1'b0;
        id_reg_write = 1'b0; exmem_reg_write = 1'b0; exmem_rd = '0;
        exmem_result = '0; memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
        @(posedge clk);
        #1;

        // Reset held with busy ID inputs, then released between edges.
        s = idleStim();
        s.rstN = 1'b0; s.idValid = 1'b1; s.opcode = 4'hB; s.rs = 4'd6; s.rt = 4'd7;
        s.rd = 4'd2; s.rsData = 16'hBEEF; s.rtData = 16'hCAFE; s.imm = 16'h0F0F;
        s.regWrite = 1'b1; s.exWe = 1'b1; s.exRd = 4'd6; s.exRes = 16'h1111;
        applyStimulus(s);
        applyStimulus(s);
        s = idleStim();
        s.idValid = 1'b1; s.opcode = 4'h1; s.rs = 4'd3; s.rd = 4'd1;
        s.rsData = 16'h1234; s.regWrite = 1'b1;
        applyStimulus(s);

        // Priority forwarding: EX/MEM beats MEM/WB, then MEM/WB alone.
        s = idleStim();
        s.idValid = 1'b1; s.opcode = 4'h2; s.rs = 4'd5; s.rt = 4'd5; s.rd = 4'd6;
        s.rsData = 16'h0101; s.rtData = 16'h0202; s.regWrite = 1'b1;
        applyStimulus(s);
        s.exWe = 1'b1; s.exRd = 4'd5; s.exRes = 16'hAAAA;
        s.wbWe = 1'b1; s.wbRd = 4'd5; s.wbRes = 16'h5555;
        applyStimulus(s);
        s.exWe = 1'b0;
        applyStimulus(s);

        // R0 guard.
        s = idleStim();
        s.idValid = 1'b1; s.opcode = 4'h3; s.rs = 4'd0; s.rsData = 16'hFFFF;
        applyStimulus(s);
        s.exWe = 1'b1; s.exRd = 4'd0; s.exRes = 16'h7777;
        applyStimulus(s);

        // Stall capture of a MEM/WB value that retires during the stall.
        s = idleStim();
        s.idValid = 1'b1; s.opcode = 4'h7; s.rt = 4'd2; s.rd = 4'd3; s.rtData = 16'h0011;
        s.regWrite = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.stall = 1'b1; s.idValid = 1'b1; s.opcode = 4'hE; s.rd = 4'd9;
        s.wbWe = 1'b1; s.wbRd = 4'd2; s.wbRes = 16'h00C3;
        applyStimulus(s);
        s.stall = 1'b1; s.wbRd = 4'd9; s.wbRes = 16'h9999;
        applyStimulus(s);

        // Immediate select overrides a matching EX/MEM producer.
        s = idleStim();
        s.idValid = 1'b1; s.opcode = 4'h4; s.rt = 4'd4; s.rd = 4'd4;
        s.useImm = 1'b1; s.imm = 16'hFFF8; s.rtData = 16'h4444; s.regWrite = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.exWe = 1'b1; s.exRd = 4'd4; s.exRes = 16'h8888;
        s.stall = 1'b1;
        applyStimulus(s);

        // Flush together with stall on a valid instruction, then a fresh load.
        s.flush = 1'b1;
        applyStimulus(s);
        rsv = idleStim();
        rsv.idValid = 1'b1; rsv.opcode = 4'h9; rsv.rs = 4'd1; rsv.rt = 4'd2; rsv.rd = 4'd3;
        rsv.rsData = 16'h1357; rsv.rtData = 16'h2468; rsv.regWrite = 1'b1;
        applyStimulus(rsv);
        applyStimulus(idleStim());

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(randomStim());
        end
        applyStimulus(idleStim());

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            errorCount++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
